// File: rtl/snitch_apb_initiator_pkg.sv
// Shared types for the snitch APB4 initiator.
// Holds the default APB request/response structs and the width constants behind them.
package snitch_apb_initiator_pkg;

    localparam int unsigned ApbAddrWidth = 32;
    localparam int unsigned ApbDataWidth = 32;
    localparam int unsigned ApbStrbWidth = ApbDataWidth / 8;

    typedef logic [ApbAddrWidth-1:0] apb_addr_t;
    typedef logic [ApbDataWidth-1:0] apb_data_t;
    typedef logic [ApbStrbWidth-1:0] apb_strb_t;
    typedef logic [2:0]              apb_prot_t;

    typedef struct packed {
        apb_addr_t paddr;
        apb_prot_t pprot;
        logic      psel;
        logic      penable;
        logic      pwrite;
        apb_data_t pwdata;
        apb_strb_t pstrb;
    } apb_req_t;

    typedef struct packed {
        logic      pready;
        apb_data_t prdata;
        logic      pslverr;
    } apb_resp_t;

endpackage

// File: rtl/snitch_apb_initiator.sv
// APB4 initiator: one valid/ready request becomes one APB transfer, one valid/ready response.
// Ports: clk_i/rst_ni, req_* request channel, rsp_* response channel, timeout_o pulse, apb_req_o/apb_resp_i.
module snitch_apb_initiator
    import snitch_apb_initiator_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned StrbWidth     = DataWidth / 8,
    parameter int unsigned TimeoutCycles = 256,
    parameter type         apb_req_t     = snitch_apb_initiator_pkg::apb_req_t,
    parameter type         apb_resp_t    = snitch_apb_initiator_pkg::apb_resp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [StrbWidth-1:0] req_strb_i,
    input  logic [2:0]           req_prot_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic                 timeout_o,
    output apb_req_t             apb_req_o,
    input  apb_resp_t            apb_resp_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [AddrWidth-1:0] addr_q;
    logic                 write_q;
    logic [DataWidth-1:0] wdata_q;
    logic [StrbWidth-1:0] strb_q;
    logic [2:0]           prot_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 error_q;
    logic                 timeout_q;

    logic psel;
    logic penable;
    logic accept;
    logic done;
    logic timeout_hit;

    // Forced abort when the responder stalls too long; pready always wins.
    if (TimeoutCycles > 0) begin : g_timeout
        localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
        logic [CntW-1:0] cnt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (state_q == SETUP) begin
                cnt_q <= '0;
            end else if (state_q == ACCESS && !apb_resp_i.pready) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end

        assign timeout_hit = (state_q == ACCESS)
                           && !apb_resp_i.pready
                           && (cnt_q == CntW'(TimeoutCycles - 1));
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        psel        = 1'b0;
        penable     = 1'b0;
        accept      = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (apb_resp_i.pready) begin
                    done    = 1'b1;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
        end else if (accept) begin
            addr_q  <= req_addr_i;
            write_q <= req_write_i;
            wdata_q <= req_wdata_i;
            strb_q  <= req_strb_i;
            prot_q  <= req_prot_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (done) begin
                rdata_q <= write_q ? '0 : apb_resp_i.prdata;
                error_q <= apb_resp_i.pslverr;
            end else if (timeout_hit) begin
                rdata_q   <= '0;
                error_q   <= 1'b1;
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        apb_req_o         = '0;
        apb_req_o.paddr   = addr_q;
        apb_req_o.pprot   = prot_q;
        apb_req_o.psel    = psel;
        apb_req_o.penable = penable;
        apb_req_o.pwrite  = write_q;
        apb_req_o.pwdata  = wdata_q;
        // Reads never carry strobes on APB4.
        apb_req_o.pstrb   = write_q ? strb_q : '0;
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_snitch_apb_initiator.sv
// Directed bench for snitch_apb_initiator.
// Drives requests and a scripted APB responder, checks timing and values cycle by cycle.
module tb_snitch_apb_initiator;
    import snitch_apb_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        timeout;
    apb_req_t    apb_req;
    apb_resp_t   apb_resp;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    snitch_apb_initiator #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_write_i(req_write),
        .req_wdata_i(req_wdata),
        .req_strb_i (req_strb),
        .req_prot_i (req_prot),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error),
        .timeout_o  (timeout),
        .apb_req_o  (apb_req),
        .apb_resp_i (apb_resp)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in the SETUP cycle.
    task automatic issue(input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_strb  = s;
        req_prot  = 3'b010;
        chk("issue_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic ack();
        apb_resp  = '0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("ack_idle_ready", req_ready, 1'b1);
        chk("ack_rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        rsp_ready = 1'b0;
        apb_resp  = '0;
        #12;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_apb_req", apb_req, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // zero-wait write
        issue(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
        chk("wr_c1_psel", apb_req.psel, 1'b1);
        chk("wr_c1_penable", apb_req.penable, 1'b0);
        chk("wr_c1_pstrb", apb_req.pstrb, 4'hF);
        chk("wr_c1_paddr", apb_req.paddr, 32'h10);
        chk("wr_c1_pwrite", apb_req.pwrite, 1'b1);
        chk("wr_c1_pwdata", apb_req.pwdata, 32'hDEADBEEF);
        chk("wr_c1_pprot", apb_req.pprot, 3'b010);
        chk("wr_c1_ready", req_ready, 1'b0);
        apb_resp.pready = 1'b1;
        step();
        chk("wr_c2_psel", apb_req.psel, 1'b1);
        chk("wr_c2_penable", apb_req.penable, 1'b1);
        chk("wr_c2_rsp_valid", rsp_valid, 1'b0);
        step();
        chk("wr_c3_rsp_valid", rsp_valid, 1'b1);
        chk("wr_c3_error", rsp_error, 1'b0);
        chk("wr_c3_rdata", rsp_rdata, 32'h0);
        chk("wr_c3_psel", apb_req.psel, 1'b0);
        chk("wr_c3_penable", apb_req.penable, 1'b0);
        chk("wr_c3_ready", req_ready, 1'b0);
        ack();

        // read with 3 wait states
        issue(32'h28, 1'b0, 32'h0, 4'hF);
        chk("rd_c1_pstrb", apb_req.pstrb, 4'h0);
        chk("rd_c1_pwrite", apb_req.pwrite, 1'b0);
        step();
        step();
        step();
        step();
        chk("rd_c5_penable", apb_req.penable, 1'b1);
        chk("rd_c5_paddr", apb_req.paddr, 32'h28);
        chk("rd_c5_rsp_valid", rsp_valid, 1'b0);
        apb_resp.pready = 1'b1;
        apb_resp.prdata = 32'h42;
        step();
        chk("rd_c6_rsp_valid", rsp_valid, 1'b1);
        chk("rd_c6_rdata", rsp_rdata, 32'h42);
        chk("rd_c6_error", rsp_error, 1'b0);
        ack();

        // slave error on read
        issue(32'h30, 1'b0, 32'h0, 4'h0);
        apb_resp.pready  = 1'b1;
        apb_resp.pslverr = 1'b1;
        apb_resp.prdata  = 32'h77;
        step();
        step();
        chk("se_rsp_valid", rsp_valid, 1'b1);
        chk("se_error", rsp_error, 1'b1);
        chk("se_timeout", timeout, 1'b0);
        chk("se_rdata", rsp_rdata, 32'h77);
        ack();

        // timeout after 8 ACCESS cycles
        issue(32'h40, 1'b0, 32'h0, 4'h0);
        apb_resp.prdata = 32'h55;
        for (int i = 2; i <= 9; i++) begin
            step();
            chk("to_psel", apb_req.psel, 1'b1);
            chk("to_penable", apb_req.penable, 1'b1);
        end
        chk("to_c9_pulse", timeout, 1'b0);
        chk("to_c9_rsp_valid", rsp_valid, 1'b0);
        step();
        chk("to_c10_pulse", timeout, 1'b1);
        chk("to_c10_error", rsp_error, 1'b1);
        chk("to_c10_rdata", rsp_rdata, 32'h0);
        chk("to_c10_psel", apb_req.psel, 1'b0);
        chk("to_c10_rsp_valid", rsp_valid, 1'b1);
        ack();
        chk("to_c11_pulse", timeout, 1'b0);

        // pready in the 8th ACCESS cycle beats the timeout
        issue(32'h44, 1'b0, 32'h0, 4'h0);
        step();
        repeat (7) step();
        chk("tv_c9_penable", apb_req.penable, 1'b1);
        apb_resp.pready = 1'b1;
        apb_resp.prdata = 32'h99;
        step();
        chk("tv_rsp_valid", rsp_valid, 1'b1);
        chk("tv_pulse", timeout, 1'b0);
        chk("tv_error", rsp_error, 1'b0);
        chk("tv_rdata", rsp_rdata, 32'h99);
        ack();

        // response back-pressure with a pending request
        issue(32'h50, 1'b0, 32'h0, 4'h0);
        apb_resp.pready = 1'b1;
        apb_resp.prdata = 32'hA5;
        step();
        step();
        apb_resp  = '0;
        req_valid = 1'b1;
        req_addr  = 32'h60;
        req_write = 1'b1;
        req_wdata = 32'h1234;
        req_strb  = 4'h3;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rdata", rsp_rdata, 32'hA5);
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_psel", apb_req.psel, 1'b0);
            step();
        end
        chk("bp_hold_rsp_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_idle_ready", req_ready, 1'b1);
        chk("bp_idle_rsp_valid", rsp_valid, 1'b0);
        chk("bp_idle_psel", apb_req.psel, 1'b0);
        step();
        req_valid = 1'b0;
        chk("bp_next_psel", apb_req.psel, 1'b1);
        chk("bp_next_paddr", apb_req.paddr, 32'h60);
        chk("bp_next_pstrb", apb_req.pstrb, 4'h3);
        apb_resp.pready = 1'b1;
        step();
        step();
        chk("bp_next_rsp_valid", rsp_valid, 1'b1);
        chk("bp_next_rdata", rsp_rdata, 32'h0);
        ack();

        // asynchronous reset during ACCESS wait states
        issue(32'h70, 1'b0, 32'h0, 4'h0);
        step();
        step();
        chk("ar_pre_penable", apb_req.penable, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_psel", apb_req.psel, 1'b0);
        chk("ar_penable", apb_req.penable, 1'b0);
        chk("ar_rsp_valid", rsp_valid, 1'b0);
        chk("ar_req_ready", req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ar_hold_rsp_valid", rsp_valid, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ar_after_rsp_valid", rsp_valid, 1'b0);
        issue(32'h74, 1'b0, 32'h0, 4'h0);
        chk("ar_fresh_paddr", apb_req.paddr, 32'h74);
        apb_resp.pready = 1'b1;
        apb_resp.prdata = 32'h00C0FFEE;
        step();
        step();
        chk("ar_fresh_rsp_valid", rsp_valid, 1'b1);
        chk("ar_fresh_rdata", rsp_rdata, 32'h00C0FFEE);
        chk("ar_fresh_error", rsp_error, 1'b0);
        ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
